gf2m_pow_serial: RTL and testbench

//  Iterative GF(2^M) exponentiation unit: computes y = x^EXP by left-to-right

---
 rtl/gf2m_pow_serial.sv | 120 ++++++++++++
 tb/tb_gf2m_pow_serial.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/gf2m_pow_serial.sv
// Serial GF(2^M) exponentiator: y = x^EXP via left-to-right square-and-multiply, one shared multiplier.
// Optional GF_POW_INV_MODE_EN adds inv_mode, which selects exponent 2^M-2 (field inverse).
module gf2m_pow_serial #(
  parameter int unsigned M    = 8,
  parameter int unsigned POLY = 32'h163,
  parameter int unsigned EXP  = 247
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [M-1:0] x_in,
`ifdef GF_POW_INV_MODE_EN
  input  logic         inv_mode,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [M-1:0] y_out,
  output logic         busy
);

  localparam int unsigned IW = (M > 1) ? $clog2(M) : 1;
  localparam logic [M-1:0] RED     = M'(POLY);
  localparam logic [M-1:0] EXP_V   = M'(EXP);
  localparam logic [M-1:0] INV_EXP = {{(M-1){1'b1}}, 1'b0};
  localparam logic [M-1:0] ONE     = M'(1);

  typedef enum logic [1:0] {IDLE, SQR, MUL, DONE} state_t;

  state_t         state;
  logic [M-1:0]   acc;
  logic [M-1:0]   x_reg;
  logic [IW-1:0]  idx;
  logic [M-1:0]   exp_v;
  logic [M-1:0]   mul_b;
  logic [M-1:0]   prod;
  logic [M-1:0]   mul_res;

  // Horner-style carry-less multiply with reduction folded into every shift.
  function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
    logic [M-1:0] p;
    p = '0;
    for (int i = M - 1; i >= 0; i--) begin
      p = {p[M-2:0], 1'b0} ^ (p[M-1] ? RED : '0);
      if (b[i]) p = p ^ a;
    end
    return p;
  endfunction

`ifdef GF_POW_INV_MODE_EN
  logic [M-1:0] exp_reg;
  assign exp_v = exp_reg;
`else
  assign exp_v = EXP_V;
`endif

  // Single multiplier: squares in SQR, multiplies by the operand in MUL.
  assign mul_b   = (state == SQR) ? acc : x_reg;
  assign prod    = gf_mul(acc, mul_b);
  assign mul_res = exp_v[idx] ? prod : acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      y_out     <= '0;
      busy      <= 1'b0;
      acc       <= ONE;
      idx       <= IW'(M - 1);
      x_reg     <= '0;
`ifdef GF_POW_INV_MODE_EN
      exp_reg   <= EXP_V;
`endif
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            x_reg    <= x_in;
            acc      <= ONE;
            idx      <= IW'(M - 1);
            in_ready <= 1'b0;
            busy     <= 1'b1;
`ifdef GF_POW_INV_MODE_EN
            exp_reg  <= inv_mode ? INV_EXP : EXP_V;
`endif
            state    <= SQR;
          end
        end
        SQR: begin
          acc   <= prod;
          state <= MUL;
        end
        // The multiply slot is always spent so timing is data independent.
        MUL: begin
          acc <= mul_res;
          if (idx == '0) begin
            y_out     <= mul_res;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            idx   <= idx - IW'(1);
            state <= SQR;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gf2m_pow_serial.sv
// Self-checking bench for gf2m_pow_serial against a repeated-multiplication GF(2^8) model.
module tb_gf2m_pow_serial;

  localparam int unsigned M   = 8;
  localparam int unsigned LAT = 2 * M;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0, out_ready = 1'b0;
  logic [7:0] x_in = '0;
  logic       in_ready, out_valid, busy;
  logic [7:0] y_out;
  logic       sq_in_valid = 1'b0, sq_out_ready = 1'b0;
  logic [7:0] sq_x_in = '0;
  logic       sq_in_ready, sq_out_valid, sq_busy;
  logic [7:0] sq_y_out;
`ifdef GF_POW_INV_MODE_EN
  logic       inv_mode = 1'b0;
  logic       sq_inv_mode = 1'b0;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  gf2m_pow_serial #(.M(8), .POLY(32'h163), .EXP(247)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .x_in(x_in),
`ifdef GF_POW_INV_MODE_EN
    .inv_mode(inv_mode),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .y_out(y_out), .busy(busy));

  gf2m_pow_serial #(.M(8), .POLY(32'h163), .EXP(2)) u_sq (
    .clk(clk), .rst(rst), .in_valid(sq_in_valid), .in_ready(sq_in_ready), .x_in(sq_x_in),
`ifdef GF_POW_INV_MODE_EN
    .inv_mode(sq_inv_mode),
`endif
    .out_valid(sq_out_valid), .out_ready(sq_out_ready), .y_out(sq_y_out), .busy(sq_busy));

  // Reference: shift-and-add multiply, LSB first, with xtime doubling.
  function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r = '0;
    logic [7:0] t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ t;
      t = t[7] ? ((t << 1) ^ 8'h63) : (t << 1);
    end
    return r;
  endfunction

  function automatic logic [7:0] ref_pow(input logic [7:0] x, input int e);
    logic [7:0] r = 8'h01;
    for (int k = 0; k < e; k++) r = ref_mul(r, x);
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One full transaction on the selected instance; returns result and accept-to-valid latency.
  task automatic run_op(input bit sel, input logic [7:0] x, input bit im,
                        output logic [7:0] y, output int lat);
    int n = 0;
    while (!(sel ? sq_in_ready : in_ready) && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 100) check("in_ready_timeout", 0, 1);
    if (sel) begin sq_in_valid = 1'b1; sq_x_in = x; end
    else begin in_valid = 1'b1; x_in = x; end
`ifdef GF_POW_INV_MODE_EN
    inv_mode = im;
`else
    if (im) $display("inv_mode request ignored in this build");
`endif
    @(posedge clk); #1;
    in_valid = 1'b0; sq_in_valid = 1'b0;
    lat = 0;
    while (!(sel ? sq_out_valid : out_valid) && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    y = sel ? sq_y_out : y_out;
    if (sel) sq_out_ready = 1'b1; else out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; sq_out_ready = 1'b0;
  endtask

  initial begin
    logic [7:0] y, x, y_hold, xs;
    logic [7:0] expq[$];
    int lat, last_rise, ncyc, nres;

    // Reset values while rst is held
    #2;
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_y_out", 32'(y_out), 0);
    check("rst_busy", 32'(busy), 0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("idle_in_ready", 32'(in_ready), 1);
    check("idle_busy", 32'(busy), 0);

    // Squaring instance: 0x80^2 = 0x64, latency 16
    run_op(1'b1, 8'h80, 1'b0, y, lat);
    check("sq_80_value", 32'(y), 32'h64);
    check("sq_80_model", 32'(y), 32'(ref_pow(8'h80, 2)));
    check("sq_latency", 32'(lat), LAT);
    xs = 8'($urandom);
    run_op(1'b1, xs, 1'b0, y, lat);
    check("sq_rand", 32'(y), 32'(ref_pow(xs, 2)));

    // Full sweep of x^247
    for (int i = 0; i < 256; i++) begin
      run_op(1'b0, 8'(i), 1'b0, y, lat);
      check($sformatf("pow247_x%02h", i), 32'(y), 32'(ref_pow(8'(i), 247)));
      check("pow247_latency", 32'(lat), LAT);
      if (i == 0) check("pow247_zero", 32'(y), 32'h00);
      if (i == 1) check("pow247_one", 32'(y), 32'h01);
    end

    // Backpressure: hold result 5 cycles while pulsing in_valid
    x = 8'($urandom);
    in_valid = 1'b1; x_in = x;
    @(posedge clk); #1 in_valid = 1'b0;
    ncyc = 0;
    while (!out_valid && ncyc < 100) begin @(posedge clk); #1; ncyc++; end
    check("hold_latency", 32'(ncyc), LAT);
    y_hold = y_out;
    check("hold_value", 32'(y_hold), 32'(ref_pow(x, 247)));
    for (int c = 0; c < 5; c++) begin
      in_valid = c[0]; x_in = 8'($urandom);
      @(posedge clk); #1;
      check("hold_out_valid", 32'(out_valid), 1);
      check("hold_y_stable", 32'(y_out), 32'(y_hold));
      check("hold_in_ready", 32'(in_ready), 0);
      check("hold_busy", 32'(busy), 1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    check("post_hs_out_valid", 32'(out_valid), 0);
    check("post_hs_in_ready", 32'(in_ready), 1);
    check("post_hs_busy", 32'(busy), 0);

    // Back-to-back with in_valid and out_ready held high
    in_valid = 1'b1; out_ready = 1'b1;
    last_rise = -1; nres = 0; ncyc = 0;
    while (nres < 4 && ncyc < 200) begin
      if (in_ready && expq.size() < 4 - nres) begin
        x_in = 8'($urandom);
        expq.push_back(ref_pow(x_in, 247));
      end
      @(posedge clk); #1; ncyc++;
      if (in_ready && out_valid) check("b2b_ready_with_valid", 1, 0);
      if (out_valid) begin
        check("b2b_value", 32'(y_out), 32'(expq.pop_front()));
        if (last_rise >= 0) check("b2b_period", 32'(ncyc - last_rise), 2 * M + 2);
        last_rise = ncyc; nres++;
      end
    end
    if (nres < 4) check("b2b_timeout", 32'(nres), 4);
    in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Abort with reset on cycle 7 of an operation
    in_valid = 1'b1; x_in = 8'($urandom);
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("abort_busy_before", 32'(busy), 1);
    rst = 1'b1;
    #1;
    check("abort_out_valid", 32'(out_valid), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_in_ready", 32'(in_ready), 0);
    @(posedge clk); #1;
    check("abort_no_result", 32'(out_valid), 0);
    rst = 1'b0;
    run_op(1'b0, 8'h01, 1'b0, y, lat);
    check("abort_next_value", 32'(y), 32'h01);
    check("abort_next_latency", 32'(lat), LAT);

`ifdef GF_POW_INV_MODE_EN
    // Inverse mode
    for (int i = 0; i < 256; i++) begin
      run_op(1'b0, 8'(i), 1'b1, y, lat);
      if (i == 0) check("inv_zero", 32'(y), 0);
      else check($sformatf("inv_x%02h", i), 32'(ref_mul(8'(i), y)), 1);
      check("inv_latency", 32'(lat), LAT);
    end
    run_op(1'b0, 8'h80, 1'b0, y, lat);
    check("inv_off_value", 32'(y), 32'(ref_pow(8'h80, 247)));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
